// File: rtl/ln_row_loader_if.sv
// Element stream into the layer-norm row loader: one fixed-point element per
// beat, with the row's gamma/beta sampled alongside the closing element.
interface ln_row_loader_if #(
  parameter int IL = 4,
  parameter int FL = 16
);
  logic signed [IL+FL-1:0] in_data;
  logic signed [IL+FL-1:0] in_gamma;
  logic signed [IL+FL-1:0] in_beta;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;

  modport master (
    output in_data, in_valid, in_last, in_gamma, in_beta,
    input  in_ready
  );

  modport slave (
    input  in_data, in_valid, in_last, in_gamma, in_beta,
    output in_ready
  );
endinterface

// File: rtl/ln_row_loader.sv
// Packs a valid/ready element stream into ping-pong row banks for forward.
// Optional LN_ROW_LOADER_ZERO_PAD_EN zeroes presented lanes at index >= num.
module ln_row_loader #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int size  = 16,
  parameter int width = $clog2(size)
) (
  input  logic                        clk,
  input  logic                        reset,
  ln_row_loader_if.slave              s,
  input  logic [1:0]                  ds_state,
  output logic [size-1:0][IL+FL-1:0]  batch,
  output logic [width:0]              num,
  output logic signed [IL+FL-1:0]     gamma,
  output logic signed [IL+FL-1:0]     beta,
  output logic                        input_ready,
  output logic                        split
);

  localparam int unsigned EW = IL + FL;
  localparam int unsigned NW = width + 1;
  localparam logic [width-1:0] LAST_LANE = width'(size - 1);

  logic [EW-1:0]    lanes     [2][size];
  logic [NW-1:0]    row_num   [2];
  logic [EW-1:0]    row_gamma [2];
  logic [EW-1:0]    row_beta  [2];
  logic [1:0]       full;
  logic             fill;
  logic             rptr;
  logic [width-1:0] wptr;

  logic accept;
  logic close;
  logic handoff;

  // A bank being written is never full, so write and release never collide.
  assign s.in_ready = !full[fill] && !reset;
  assign accept     = s.in_valid && s.in_ready;
  assign close      = s.in_last || (wptr == LAST_LANE);
  assign handoff    = full[rptr] && (ds_state == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < size; i++) begin
          lanes[b][i] <= '0;
        end
        row_num[b]   <= '0;
        row_gamma[b] <= '0;
        row_beta[b]  <= '0;
      end
      full  <= '0;
      fill  <= 1'b0;
      rptr  <= 1'b0;
      wptr  <= '0;
      split <= 1'b0;
    end else begin
      split <= 1'b0;

      if (handoff) begin
        full[rptr] <= 1'b0;
        for (int i = 0; i < size; i++) begin
          lanes[rptr][i] <= '0;
        end
        rptr <= ~rptr;
      end

      if (accept) begin
        lanes[fill][wptr] <= s.in_data;
        if (close) begin
          full[fill]      <= 1'b1;
          row_num[fill]   <= NW'(wptr) + NW'(1);
          row_gamma[fill] <= s.in_gamma;
          row_beta[fill]  <= s.in_beta;
          wptr            <= '0;
          fill            <= ~fill;
          split           <= !s.in_last;
        end else begin
          wptr <= wptr + width'(1);
        end
      end
    end
  end

  // Presentation mux, selected by the registered read pointer only.
  always_comb begin
    input_ready = full[rptr];
    num         = row_num[rptr];
    gamma       = row_gamma[rptr];
    beta        = row_beta[rptr];
    for (int i = 0; i < size; i++) begin
      batch[i] = lanes[rptr][i];
`ifdef LN_ROW_LOADER_ZERO_PAD_EN
      if (NW'(i) >= row_num[rptr]) begin
        batch[i] = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ln_row_loader.sv
// Bench for ln_row_loader: directed scenarios plus a random phase, checked
// against a row-queue reference model of the loader's behaviour.
module tb_ln_row_loader;

  localparam int IL   = 4;
  localparam int FL   = 16;
  localparam int SIZE = 16;
  localparam int W    = $clog2(SIZE);
  localparam int EW   = IL + FL;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [1:0]                ds_state;
  logic [SIZE-1:0][EW-1:0]   batch;
  logic [W:0]                num;
  logic [EW-1:0]             gamma;
  logic [EW-1:0]             beta;
  logic                      input_ready;
  logic                      split;

  ln_row_loader_if #(.IL(IL), .FL(FL)) s();

  ln_row_loader #(.IL(IL), .FL(FL), .size(SIZE), .width(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s),
    .ds_state   (ds_state),
    .batch      (batch),
    .num        (num),
    .gamma      (gamma),
    .beta       (beta),
    .input_ready(input_ready),
    .split      (split)
  );

  always #5 clk = ~clk;

  // Reference model: closed rows awaiting handoff, plus the row being built.
  typedef struct {
    logic [EW-1:0] e [SIZE];
    int            n;
    logic [EW-1:0] g;
    logic [EW-1:0] b;
  } row_t;

  row_t          pend [$];
  logic [EW-1:0] cur  [$];
  bit            split_exp = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            split_seen = 0;
  logic [EW-1:0] g_drv = '0;
  logic [EW-1:0] b_drv = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs against the model, then advance both.
  task automatic cyc(input bit v, input logic [EW-1:0] d, input bit l,
                     input logic [1:0] ds, input bit rst);
    row_t r;
    bit   acc;
    bit   ho;
    bit   closed;
    s.in_valid = v;
    s.in_data  = d;
    s.in_last  = l;
    s.in_gamma = g_drv;
    s.in_beta  = b_drv;
    ds_state   = ds;
    reset      = rst;
    #1;
    chk("in_ready", 64'(s.in_ready), 64'(!rst && pend.size() < 2));
    chk("split", 64'(split), 64'(split_exp));
    if (split) split_seen++;
    chk("input_ready", 64'(input_ready), 64'(pend.size() > 0));
    if (pend.size() > 0) begin
      chk("num", 64'(num), 64'(pend[0].n));
      chk("gamma", 64'(gamma), 64'(pend[0].g));
      chk("beta", 64'(beta), 64'(pend[0].b));
      for (int i = 0; i < SIZE; i++) begin
        if (i < pend[0].n) chk($sformatf("lane%0d", i), 64'(batch[i]), 64'(pend[0].e[i]));
`ifdef LN_ROW_LOADER_ZERO_PAD_EN
        else chk($sformatf("pad%0d", i), 64'(batch[i]), 64'(0));
`endif
      end
    end

    acc    = v && !rst && (pend.size() < 2);
    closed = 1'b0;
    if (rst) begin
      pend.delete();
      cur.delete();
      split_exp = 1'b0;
    end else begin
      ho        = (pend.size() > 0) && (ds == 2'b00);
      split_exp = 1'b0;
      if (acc) begin
        cur.push_back(d);
        if (l || cur.size() == SIZE) begin
          for (int i = 0; i < SIZE; i++) r.e[i] = (i < cur.size()) ? cur[i] : '0;
          r.n       = cur.size();
          r.g       = g_drv;
          r.b       = b_drv;
          split_exp = !l;
          closed    = 1'b1;
          cur.delete();
        end
      end
      if (ho) void'(pend.pop_front());
      if (closed) pend.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    logic [EW-1:0] d;
    int            rr;
    s.in_valid = 1'b0;
    s.in_data  = '0;
    s.in_last  = 1'b0;
    s.in_gamma = '0;
    s.in_beta  = '0;
    ds_state   = 2'b00;
    reset      = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_in_ready", 64'(s.in_ready), 64'(0));
    chk("rst_input_ready", 64'(input_ready), 64'(0));
    chk("rst_num", 64'(num), 64'(0));
    chk("rst_split", 64'(split), 64'(0));
    chk("rst_gamma", 64'(gamma), 64'(0));
    do_reset();

    // Row 3,5,7 hands off immediately
    g_drv = 20'h10000; b_drv = '0;
    cyc(1'b1, 20'h30000, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 20'h50000, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 20'h70000, 1'b1, 2'b00, 1'b0);
    chk("s1_input_ready", 64'(input_ready), 64'(1));
    chk("s1_num", 64'(num), 64'(3));
    chk("s1_lane0", 64'(batch[0]), 64'(20'h30000));
    chk("s1_lane1", 64'(batch[1]), 64'(20'h50000));
    chk("s1_lane2", 64'(batch[2]), 64'(20'h70000));
    chk("s1_gamma", 64'(gamma), 64'(20'h10000));
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);
    chk("s1_released", 64'(input_ready), 64'(0));

    // Two rows of 4 with forward busy, then a stalled 9th element
    do_reset();
    for (int i = 0; i < 8; i++) begin
      g_drv = EW'(32'h100 + i);
      b_drv = EW'(32'h200 + i);
      cyc(1'b1, EW'(32'h1000 + i), (i % 4) == 3, 2'b01, 1'b0);
    end
    chk("s2_stall", 64'(s.in_ready), 64'(0));
    cyc(1'b1, 20'h09999, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 20'h09999, 1'b0, 2'b01, 1'b0);
    chk("s2_row1_num", 64'(num), 64'(4));
    cyc(1'b1, 20'h09999, 1'b0, 2'b00, 1'b0);
    chk("s2_ready_back", 64'(s.in_ready), 64'(1));
    chk("s2_row2_present", 64'(input_ready), 64'(1));
    chk("s2_row2_lane0", 64'(batch[0]), 64'(20'h01004));
    cyc(1'b1, 20'h09999, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 20'h0aaaa, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);

    // 17 elements without in_last: forced split at 16
    do_reset();
    split_seen = 0;
    for (int i = 0; i < 16; i++) cyc(1'b1, EW'(32'h2000 + i), 1'b0, 2'b00, 1'b0);
    chk("s3_num", 64'(num), 64'(16));
    chk("s3_split", 64'(split), 64'(1));
    cyc(1'b1, 20'h02010, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 20'h02011, 1'b1, 2'b01, 1'b0);
    chk("s3_row2_lane0", 64'(batch[0]), 64'(20'h02010));
    chk("s3_row2_num", 64'(num), 64'(2));
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);
    chk("s3_split_count", 64'(split_seen), 64'(1));

    // Single-element row
    do_reset();
    cyc(1'b1, 20'hfffff, 1'b1, 2'b01, 1'b0);
    chk("s4_num", 64'(num), 64'(1));
    chk("s4_lane0", 64'(batch[0]), 64'(20'hfffff));
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);

    // Reset part-way through a row
    cyc(1'b1, 20'h0dead, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 20'h0beef, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b1);
    chk("s5_rst_ready", 64'(s.in_ready), 64'(0));
    chk("s5_no_row", 64'(input_ready), 64'(0));
    for (int i = 0; i < 4; i++) cyc(1'b1, EW'(32'h3000 + i), i == 3, 2'b01, 1'b0);
    chk("s5_num", 64'(num), 64'(4));
    chk("s5_lane0", 64'(batch[0]), 64'(20'h03000));
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);

    // Close of row B on the same edge that row A hands off
    do_reset();
    g_drv = 20'h11111; b_drv = 20'h22222;
    for (int i = 0; i < 3; i++) cyc(1'b1, EW'(32'h4000 + i), i == 2, 2'b01, 1'b0);
    g_drv = 20'h33333; b_drv = 20'h44444;
    cyc(1'b1, 20'h05000, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 20'h05001, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 20'h05002, 1'b1, 2'b00, 1'b0);
    chk("s6_present", 64'(input_ready), 64'(1));
    chk("s6_num", 64'(num), 64'(3));
    chk("s6_gamma", 64'(gamma), 64'(20'h33333));
    chk("s6_beta", 64'(beta), 64'(20'h44444));
    chk("s6_lane2", 64'(batch[2]), 64'(20'h05002));
    cyc(1'b0, '0, 1'b0, 2'b00, 1'b0);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      g_drv = EW'($urandom);
      b_drv = EW'($urandom);
      d     = EW'($urandom);
      rr    = $urandom_range(0, 3);
      cyc($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 2,
          (rr < 2) ? 2'b00 : ((rr == 2) ? 2'b01 : 2'b10),
          $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
